// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the two-port spi_if arbiter.
package spi_arbiter_pkg;

   localparam int DATAPATH_W = 8;
   localparam int NPORTS     = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } arb_st_e;

   function automatic logic [NPORTS-1:0] port_mask(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/spi_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not own last.
module rr_arb2
   import spi_arbiter_pkg::*;
(
   input  logic [NPORTS-1:0] req_in,
   input  logic              last_in,
   output logic [NPORTS-1:0] gnt_out,
   output logic              owner_out
);

   always_comb begin
      gnt_out   = '0;
      owner_out = 1'b0;
      case (req_in)
         2'b01:   owner_out = 1'b0;
         2'b10:   owner_out = 1'b1;
         2'b11:   owner_out = ~last_in;
         default: owner_out = 1'b0;
      endcase
      if (req_in != '0) gnt_out = port_mask(owner_out);
   end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_if master between the load/store unit (port 0) and the driver/debug path (port 1).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; grant on any request, sampling op/data/drv mode
// ST_ISSUE | owner latched; strobe for the op is registered out next edge
// ST_WAIT  | waiting for spi_ready_in; read strobe held for the whole read
// ST_GAP   | chip-select idle gap, down-counts GAP_CYC cycles, no grants
module spi_arbiter
   import spi_arbiter_pkg::*;
#(
   parameter int DATA_W  = DATAPATH_W,
   parameter int GAP_CYC = 2,
   parameter int GAP_W   = $clog2(GAP_CYC + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NPORTS-1:0] req_in,
   input  logic [NPORTS-1:0] we_in,
   input  logic [DATA_W-1:0] wdata0_in,
   input  logic [DATA_W-1:0] wdata1_in,
   input  logic              drv_io1_in,
   output logic [NPORTS-1:0] gnt_out,
   output logic [NPORTS-1:0] done_out,
   output logic [DATA_W-1:0] rdata_out,
   output logic              spi_send_out,
   output logic              spi_read_out,
   output logic [DATA_W-1:0] spi_data_out,
   output logic              spi_drv_out,
   input  logic              spi_ready_in,
   input  logic [DATA_W-1:0] spi_data_in
);

   arb_st_e             st_q, st_d;
   logic [NPORTS-1:0]   gnt_q, gnt_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic                last_q, last_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                send_q, send_d;
   logic                read_q, read_d;
   logic [DATA_W-1:0]   sdata_q, sdata_d;
   logic                drv_q, drv_d;

   logic [NPORTS-1:0]   pick_gnt;
   logic                pick_owner;
   logic                done_w;

   rr_arb2 u_rr_arb2 (
      .req_in    (req_in),
      .last_in   (last_q),
      .gnt_out   (pick_gnt),
      .owner_out (pick_owner)
   );

   assign done_w = (st_q == ST_WAIT) && spi_ready_in;

   always_comb begin
      st_d    = st_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      we_d    = we_q;
      last_d  = last_q;
      gap_d   = gap_q;
      rdata_d = rdata_q;
      send_d  = send_q;
      read_d  = read_q;
      sdata_d = sdata_q;
      drv_d   = drv_q;
      case (st_q)
         ST_IDLE: begin
            send_d = 1'b0;
            read_d = 1'b0;
            if (req_in != '0) begin
               st_d    = ST_ISSUE;
               gnt_d   = pick_gnt;
               owner_d = pick_owner;
               we_d    = we_in[pick_owner];
               sdata_d = pick_owner ? wdata1_in : wdata0_in;
               drv_d   = pick_owner & drv_io1_in;
            end
         end
         ST_ISSUE: begin
            st_d   = ST_WAIT;
            send_d = we_q;
            read_d = ~we_q;
         end
         ST_WAIT: begin
            send_d = 1'b0;
            if (spi_ready_in) begin
               st_d   = ST_GAP;
               if (!we_q) rdata_d = spi_data_in;
               last_d = owner_q;
               read_d = 1'b0;
               drv_d  = 1'b0;
               gnt_d  = '0;
               gap_d  = GAP_W'(GAP_CYC);
            end
         end
         ST_GAP: begin
            // Terminal count at 1 so the gap lasts exactly GAP_CYC cycles.
            if (gap_q <= GAP_W'(1)) begin
               st_d  = ST_IDLE;
               gap_d = '0;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= ST_IDLE;
         gnt_q   <= '0;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         last_q  <= 1'b1;
         gap_q   <= '0;
         rdata_q <= '0;
         send_q  <= 1'b0;
         read_q  <= 1'b0;
         sdata_q <= '0;
         drv_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
         rdata_q <= rdata_d;
         send_q  <= send_d;
         read_q  <= read_d;
         sdata_q <= sdata_d;
         drv_q   <= drv_d;
      end
   end

   // Done and read data bypass the flops so the owner sees both in the ready cycle.
   assign done_out     = done_w ? gnt_q : '0;
   assign rdata_out    = (done_w && !we_q) ? spi_data_in : rdata_q;
   assign gnt_out      = gnt_q;
   assign spi_send_out = send_q;
   assign spi_read_out = read_q;
   assign spi_data_out = sdata_q;
   assign spi_drv_out  = drv_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: expected completions queued at request time, checked on done_out.
module tb_spi_arbiter;

   localparam int DW  = 8;
   localparam int GAP = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_in, we_in;
   logic [DW-1:0] wdata0_in, wdata1_in;
   logic          drv_io1_in;
   logic [1:0]    gnt_out, done_out;
   logic [DW-1:0] rdata_out;
   logic          spi_send_out, spi_read_out, spi_drv_out;
   logic [DW-1:0] spi_data_out;
   logic          spi_ready_in;
   logic [DW-1:0] spi_data_in;

   spi_arbiter #(.DATA_W(DW), .GAP_CYC(GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_in       (req_in),
      .we_in        (we_in),
      .wdata0_in    (wdata0_in),
      .wdata1_in    (wdata1_in),
      .drv_io1_in   (drv_io1_in),
      .gnt_out      (gnt_out),
      .done_out     (done_out),
      .rdata_out    (rdata_out),
      .spi_send_out (spi_send_out),
      .spi_read_out (spi_read_out),
      .spi_data_out (spi_data_out),
      .spi_drv_out  (spi_drv_out),
      .spi_ready_in (spi_ready_in),
      .spi_data_in  (spi_data_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int last_done_cyc = 0;

   typedef struct {
      logic [1:0]    done;
      logic          is_rd;
      logic [DW-1:0] rdata;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic raise(input int port, input bit we, input logic [DW-1:0] wd, input logic [DW-1:0] rd);
      exp_t e;
      we_in[port] = we;
      if (port == 0) wdata0_in = wd; else wdata1_in = wd;
      req_in[port] = 1'b1;
      e.done  = (port == 0) ? 2'b01 : 2'b10;
      e.is_rd = !we;
      e.rdata = rd;
      sb.push_back(e);
   endtask

   // Monitor: one-hot grant every cycle, completions popped in order.
   always @(negedge clk) begin
      #1;
      chk("gnt_onehot0", 32'($onehot0(gnt_out)), 32'd1);
      if (done_out != 2'b00) begin
         if (sb.size() == 0) begin
            chk("spurious_done", done_out, 2'b00);
         end else begin
            mon_e = sb.pop_front();
            chk("done_owner", done_out, mon_e.done);
            if (mon_e.is_rd) chk("rdata_at_done", rdata_out, mon_e.rdata);
         end
      end
   end

   // Plays spi_if for one granted transaction; returns in the first gap cycle.
   task automatic serve(input int port, input bit we, input logic [DW-1:0] wd, input bit drv,
                        input logic [DW-1:0] rd, input int lat, input bit scramble,
                        input bit drop_early, input bit chk_turn);
      int n = 0;
      logic [1:0] strb;
      strb = we ? 2'b10 : 2'b01;
      while (gnt_out == 2'b00 && n < 40) begin
         @(negedge clk); #1; n++;
      end
      if (gnt_out == 2'b00) begin
         chk("grant_timeout", n, 0);
         return;
      end
      chk("gnt_owner", gnt_out, 2'b01 << port);
      chk("issue_no_strobe", {spi_send_out, spi_read_out}, 2'b00);
      chk("spi_data", spi_data_out, wd);
      chk("spi_drv", spi_drv_out, drv);
      if (scramble) begin
         we_in[port] = ~we;
         if (port == 0) wdata0_in = ~wd; else wdata1_in = ~wd;
         drv_io1_in = ~drv_io1_in;
      end
      @(negedge clk); #1;
      chk("strobe_first", {spi_send_out, spi_read_out}, strb);
      if (chk_turn) chk("turnaround", cyc - last_done_cyc - 1, GAP + 2);
      if (drop_early) req_in[port] = 1'b0;
      for (int i = 0; i < lat; i++) begin
         @(negedge clk); #1;
         chk("strobe_wait", {spi_send_out, spi_read_out}, we ? 2'b00 : 2'b01);
         chk("gnt_held", gnt_out, 2'b01 << port);
      end
      @(negedge clk);
      spi_ready_in = 1'b1;
      spi_data_in  = rd;
      #1;
      last_done_cyc = cyc;
      chk("spi_data_hold", spi_data_out, wd);
      chk("spi_drv_hold", spi_drv_out, drv);
      @(negedge clk);
      spi_ready_in = 1'b0;
      spi_data_in  = 8'hEE;
      req_in[port] = 1'b0;
      #1;
      chk("gap_gnt", gnt_out, 2'b00);
      chk("gap_strobes", {spi_send_out, spi_read_out}, 2'b00);
      if (!we) chk("rdata_hold", rdata_out, rd);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, gnt_out, 0);
      chk({tag, "_done"}, done_out, 0);
      chk({tag, "_rdata"}, rdata_out, 0);
      chk({tag, "_strobes"}, {spi_send_out, spi_read_out, spi_drv_out}, 0);
      chk({tag, "_sdata"}, spi_data_out, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] wd_tab [4];
      int n;
      wd_tab[0] = 8'h11; wd_tab[1] = 8'h22; wd_tab[2] = 8'h33; wd_tab[3] = 8'h44;
      rst = 1'b1; req_in = 2'b00; we_in = 2'b00; wdata0_in = '0; wdata1_in = '0;
      drv_io1_in = 1'b0; spi_ready_in = 1'b0; spi_data_in = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      // Port 0 write, drv mode must not leak to port 0
      @(negedge clk);
      drv_io1_in = 1'b1;
      raise(0, 1'b1, 8'hA5, 8'h00);
      serve(0, 1'b1, 8'hA5, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b0);

      // Port 1 driver-mode read, inputs scrambled after grant
      @(negedge clk);
      wdata1_in = 8'h00;
      drv_io1_in = 1'b1;
      raise(1, 1'b0, 8'h00, 8'h3C);
      serve(1, 1'b0, 8'h00, 1'b1, 8'h3C, 3, 1'b1, 1'b0, 1'b0);

      // Spurious ready while idle
      repeat (4) @(negedge clk);
      spi_ready_in = 1'b1;
      @(negedge clk);
      spi_ready_in = 1'b0;
      #1;
      chk("idle_spurious_gnt", gnt_out, 0);
      chk("idle_spurious_strobes", {spi_send_out, spi_read_out}, 0);

      // Contention: both pending each decision, owners must alternate 0,1,0,1
      @(negedge clk);
      drv_io1_in = 1'b0;
      raise(0, 1'b1, wd_tab[0], 8'hC0);
      raise(1, 1'b0, wd_tab[1], 8'hC1);
      for (int i = 0; i < 4; i++) begin
         serve(i % 2, (i % 2) == 0, wd_tab[i], 1'b0, 8'hC0 + 8'(i), 1 + i, 1'b0, 1'b0, i > 0);
         if (i < 2) begin
            @(negedge clk);
            raise(i % 2, (i % 2) == 0, wd_tab[i + 2], 8'hC0 + 8'(i + 2));
         end
      end

      // Port 0 drops req mid-transaction, then spurious ready in the gap
      @(negedge clk);
      raise(0, 1'b1, 8'h5A, 8'h00);
      serve(0, 1'b1, 8'h5A, 1'b0, 8'h00, 2, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      spi_ready_in = 1'b1;
      @(negedge clk);
      spi_ready_in = 1'b0;
      #1;
      chk("gap_spurious_gnt", gnt_out, 0);

      // Reset during WAIT of a port 0 read
      @(negedge clk);
      we_in[0] = 1'b0; wdata0_in = 8'h77; req_in[0] = 1'b1;
      n = 0;
      while (!spi_read_out && n < 40) begin @(negedge clk); #1; n++; end
      chk("rst_test_reached_wait", spi_read_out, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      req_in = 2'b00;
      @(negedge clk); #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;

      // After reset both request: port 0 must win, then port 1 after minimum gap
      @(negedge clk);
      drv_io1_in = 1'b0;
      raise(0, 1'b1, 8'h81, 8'h00);
      raise(1, 1'b1, 8'h18, 8'h00);
      serve(0, 1'b1, 8'h81, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
      serve(1, 1'b1, 8'h18, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1);

      repeat (4) @(negedge clk);
      #2;
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
